// File: rtl/key_search_pkg.sv
// Shared types and constants for the RC4 key-search scheduler.
// Partition bounds are elaboration-time constants; nothing here divides at runtime.
package key_search_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      LAUNCH,
      RUN,
      DONE
   } sched_state_t;

   localparam int KEY_WIDTH = 24;
   localparam logic [KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF;

   function automatic int part_start(input int i, input int n, input int kmax);
      return ((kmax + 1) / n) * i;
   endfunction

   function automatic int part_end(input int i, input int n, input int kmax);
      return ((kmax + 1) / n) * (i + 1) - 1;
   endfunction

endpackage

// File: rtl/key_search_scheduler_found_arbiter.sv
// Lowest-index priority encoder over the per-core find requests.
module found_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/key_search_scheduler.sv
// Splits the key space across NUM_CORES datapath cores, launches them,
// retires cores that leave their partition and reports the first find.
module key_search_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int KEY_WIDTH = key_search_pkg::KEY_WIDTH,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX = key_search_pkg::KEY_MAX,
   localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   output logic [NUM_CORES*KEY_WIDTH-1:0] core_key_start,
   output logic [NUM_CORES-1:0]           core_reset,
   output logic [NUM_CORES-1:0]           core_start,
   output logic [NUM_CORES-1:0]           core_stop,
   input  logic [NUM_CORES-1:0]           core_done,
   input  logic [NUM_CORES-1:0]           core_found,
   input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
   output logic                           busy,
   output logic                           done,
   output logic                           found,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [CW-1:0]                  found_core
);

   import key_search_pkg::*;

   localparam int KW = KEY_WIDTH;

   sched_state_t state, state_nx;

   logic [NUM_CORES-1:0]    fin, fin_d, fin_nx;
   logic [NUM_CORES-1:0]    over, new_fin, hit_req;
   logic [NUM_CORES*KW-1:0] key_start_c;
   logic                    hit_v;
   logic [CW-1:0]           hit_idx;

   logic [NUM_CORES-1:0]    rst_d, go_d, stop_d;
   logic                    busy_d, done_d, found_d;
   logic [KW-1:0]           fkey_d;
   logic [CW-1:0]           fcore_d;
   logic [NUM_CORES*KW-1:0] kstart_d;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      localparam logic [KW-1:0] START_I =
         KW'(part_start(i, NUM_CORES, int'(KEY_MAX)));
      localparam logic [KW-1:0] END_I =
         KW'(part_end(i, NUM_CORES, int'(KEY_MAX)));
      assign key_start_c[i*KW +: KW] = START_I;
      assign over[i] = core_key[i*KW +: KW] > END_I;
   end

   assign hit_req = core_done & core_found;
   assign new_fin = over | (core_done & ~core_found);
   assign fin_nx  = fin | new_fin;

   found_arbiter #(
      .N  (NUM_CORES),
      .IW (CW)
   ) u_arb (
      .req   (hit_req),
      .valid (hit_v),
      .idx   (hit_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RST;
         RST:     state_nx = LAUNCH;
         LAUNCH:  state_nx = RUN;
         RUN:     if (hit_v || abort || &fin_nx) state_nx = DONE;
         DONE:    if (start) state_nx = RST;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are computed for the upcoming state and registered below.
   always_comb begin
      fin_d    = fin;
      stop_d   = core_stop;
      rst_d    = '0;
      go_d     = '0;
      busy_d   = busy;
      done_d   = done;
      found_d  = found;
      fkey_d   = found_key;
      fcore_d  = found_core;
      kstart_d = core_key_start;
      if (state == RUN) begin
         if (hit_v) begin
            found_d = 1'b1;
            fkey_d  = core_key[int'(hit_idx)*KW +: KW];
            fcore_d = hit_idx;
            stop_d  = '1;
         end else begin
            fin_d  = fin_nx;
            stop_d = core_stop | new_fin;
            if (abort) stop_d = '1;
         end
      end
      unique case (state_nx)
         IDLE: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
         RST: begin
            rst_d    = '1;
            kstart_d = key_start_c;
            fin_d    = '0;
            stop_d   = '0;
            found_d  = 1'b0;
            fkey_d   = '0;
            fcore_d  = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
         end
         LAUNCH: go_d = '1;
         RUN:    ;
         DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fin            <= '0;
         core_reset     <= '1;
         core_start     <= '0;
         core_stop      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         found          <= 1'b0;
         found_key      <= '0;
         found_core     <= '0;
         core_key_start <= '0;
      end else begin
         fin            <= fin_d;
         core_reset     <= rst_d;
         core_start     <= go_d;
         core_stop      <= stop_d;
         busy           <= busy_d;
         done           <= done_d;
         found          <= found_d;
         found_key      <= fkey_d;
         found_core     <= fcore_d;
         core_key_start <= kstart_d;
      end
   end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed and randomized checks of key_search_scheduler against a
// cycle-level reference of the search rules.
module tb_key_search_scheduler;

   localparam int NC   = 4;
   localparam int KW   = 24;
   localparam int PART = 32'h400000 / NC;

   logic              clk = 1'b0;
   logic              reset, start, abort;
   logic [NC*KW-1:0]  core_key_start, core_key;
   logic [NC-1:0]     core_reset, core_start, core_stop;
   logic [NC-1:0]     core_done, core_found;
   logic              busy, done, found;
   logic [KW-1:0]     found_key;
   logic [1:0]        found_core;

   int ncmp = 0;
   int nfail = 0;

   logic [NC-1:0] mstop, mfin;
   logic          mdone, mfound;
   logic [KW-1:0] mkey;
   logic [1:0]    mcore;

   key_search_scheduler #(.NUM_CORES(NC)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .core_key_start (core_key_start),
      .core_reset     (core_reset),
      .core_start     (core_start),
      .core_stop      (core_stop),
      .core_done      (core_done),
      .core_found     (core_found),
      .core_key       (core_key),
      .busy           (busy),
      .done           (done),
      .found          (found),
      .found_key      (found_key),
      .found_core     (found_core)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] obs,
                      input logic [95:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] mk(input logic [23:0] k0, input logic [23:0] k1,
                                      input logic [23:0] k2, input logic [23:0] k3);
      return {k3, k2, k1, k0};
   endfunction

   function automatic int pend(input int i);
      return (i + 1) * PART - 1;
   endfunction

   task automatic launch();
      core_done  = '0;
      core_found = '0;
      abort      = 1'b0;
      core_key   = mk(24'h000000, 24'h100000, 24'h200000, 24'h300000);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rst_pulse", core_reset, 4'hF);
      chk("busy_rst", busy, 1'b1);
      chk("kstart", core_key_start, 96'h300000_200000_100000_000000);
      step();
      chk("rst_release", core_reset, 4'h0);
      chk("go", core_start, 4'hF);
      step();
      chk("go_pulse", core_start, 4'h0);
      mstop = '0; mfin = '0; mdone = 1'b0;
      mfound = 1'b0; mkey = '0; mcore = '0;
   endtask

   // One RUN/DONE cycle: reference decides the outcome, then the DUT is compared.
   task automatic run_cycle(input logic [95:0] keys, input logic [3:0] d,
                            input logic [3:0] f, input logic ab, input string tag);
      int w;
      core_key = keys; core_done = d; core_found = f; abort = ab;
      if (!mdone) begin
         w = -1;
         for (int i = NC - 1; i >= 0; i--) if (d[i] && f[i]) w = i;
         if (w >= 0) begin
            mfound = 1'b1;
            mkey   = keys[w*KW +: KW];
            mcore  = 2'(w);
            mstop  = '1;
            mdone  = 1'b1;
         end else begin
            for (int i = 0; i < NC; i++) begin
               if (int'(keys[i*KW +: KW]) > pend(i) || d[i]) begin
                  mfin[i]  = 1'b1;
                  mstop[i] = 1'b1;
               end
            end
            if (ab) begin
               mstop = '1;
               mdone = 1'b1;
            end
            if (&mfin) mdone = 1'b1;
         end
      end
      step();
      chk({tag, ".done"}, done, mdone);
      chk({tag, ".busy"}, busy, !mdone);
      chk({tag, ".found"}, found, mfound);
      chk({tag, ".stop"}, core_stop, mstop);
      if (mfound) begin
         chk({tag, ".key"}, found_key, mkey);
         chk({tag, ".core"}, found_core, mcore);
      end
   endtask

   initial begin
      logic [95:0] inr, rk;
      logic [3:0]  rd, rf;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      core_done = '0; core_found = '0; core_key = '0;
      inr = mk(24'h000010, 24'h100010, 24'h200010, 24'h300010);
      repeat (3) step();
      chk("r.core_reset", core_reset, 4'hF);
      chk("r.core_start", core_start, 4'h0);
      chk("r.core_stop", core_stop, 4'h0);
      chk("r.busy", busy, 1'b0);
      chk("r.done", done, 1'b0);
      chk("r.found", found, 1'b0);
      chk("r.found_key", found_key, 24'h0);
      chk("r.found_core", found_core, 2'h0);
      chk("r.kstart", core_key_start, 96'h0);
      reset = 1'b0;
      step();
      chk("idle.core_reset", core_reset, 4'h0);

      launch();
      run_cycle(inr, 4'h0, 4'h0, 1'b0, "t1a");
      run_cycle(mk(24'h000020, 24'h100020, 24'h200049, 24'h300020),
                4'b0100, 4'b0100, 1'b0, "t1b");
      chk("t1.key", found_key, 24'h200049);
      chk("t1.core", found_core, 2'd2);
      chk("t1.stop", core_stop, 4'hF);
      run_cycle(inr, 4'h0, 4'h0, 1'b1, "done_abort");

      launch();
      run_cycle(mk(24'h000010, 24'h200000, 24'h200010, 24'h300010),
                4'h0, 4'h0, 1'b0, "ovr1");
      chk("ovr1.stop_lit", core_stop, 4'b0010);
      run_cycle(mk(24'h100000, 24'h200000, 24'h200020, 24'h400000),
                4'b0100, 4'h0, 1'b0, "ovr_all");
      chk("ovr_all.done_lit", done, 1'b1);
      chk("ovr_all.found_lit", found, 1'b0);

      launch();
      run_cycle(mk(24'h000010, 24'h100011, 24'h200010, 24'h3000AA),
                4'b1010, 4'b1010, 1'b0, "sim");
      chk("sim.core_lit", found_core, 2'd1);
      chk("sim.key_lit", found_key, 24'h100011);

      launch();
      run_cycle(inr, 4'h0, 4'h0, 1'b1, "abort");
      chk("abort.found_lit", found, 1'b0);
      launch();
      run_cycle(mk(24'h000123, 24'h100010, 24'h200010, 24'h300010),
                4'b0001, 4'b0001, 1'b1, "abort_find");
      chk("abort_find.core_lit", found_core, 2'd0);

      launch();
      run_cycle(inr, 4'h0, 4'h0, 1'b0, "pre_rst");
      reset = 1'b1;
      step();
      chk("mid_rst.busy", busy, 1'b0);
      chk("mid_rst.done", done, 1'b0);
      chk("mid_rst.core_reset", core_reset, 4'hF);
      chk("mid_rst.core_start", core_start, 4'h0);
      reset = 1'b0;
      step();
      launch();
      run_cycle(mk(24'h000010, 24'h100010, 24'h200010, 24'h3ABCDE),
                4'b1000, 4'b1000, 1'b0, "post_rst");

      for (int t = 0; t < 40; t++) begin
         launch();
         for (int c = 0; c < 30 && !mdone; c++) begin
            for (int i = 0; i < NC; i++) begin
               if ($urandom % 10 == 0)
                  rk[i*KW +: KW] = KW'(i * PART + PART);
               else
                  rk[i*KW +: KW] = KW'(i * PART + int'($urandom % PART));
               rd[i] = ($urandom % 12 == 0);
               rf[i] = ($urandom % 2 == 0);
            end
            run_cycle(rk, rd, rf, ($urandom % 40 == 0), "rnd");
         end
         if (!mdone) run_cycle(inr, 4'h0, 4'h0, 1'b1, "rnd_end");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/key_search_scheduler.md
Name: key_search_scheduler

Overview:
- Sequences NUM_CORES RC4 key-search datapath cores in parallel.
- Splits the 22-bit key space 0x000000..0x3FFFFF into equal contiguous partitions and assigns one to each core.
- Resets and launches the cores, stops each core once it passes the end of its partition, and halts all cores when any core finds a key.
- Sits between the top-level (switches, HEX, LEDs) and the array of datapath instances.

Parameters:
- NUM_CORES, 4, number of datapath cores; power of two, 1..16.
- KEY_WIDTH, 24, width of a key value.
- KEY_MAX, 24'h3FFFFF, last key of the search space.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a search; sampled in IDLE and DONE
- abort  in  1  halt all cores and finish with found=0
- core_key_start  out  NUM_CORES*KEY_WIDTH  start key per core; core i occupies bits [i*24 +: 24]
- core_reset  out  NUM_CORES  per-core reset
- core_start  out  NUM_CORES  per-core start pulse
- core_stop  out  NUM_CORES  per-core stop, level
- core_done  in  NUM_CORES  datapath done flag per core
- core_found  in  NUM_CORES  key-found flag per core
- core_key  in  NUM_CORES*KEY_WIDTH  current secret key per core
- busy  out  1  high from the cycle after start until DONE
- done  out  1  high in DONE
- found  out  1  a key was found; valid while done=1
- found_key  out  KEY_WIDTH  winning key; valid while found=1
- found_core  out  $clog2(NUM_CORES) (minimum 1)  index of the winning core

Behaviour:
- All outputs are registered. Synchronous reset takes effect on the next posedge.
- Reset values:
  - state = IDLE
  - core_reset = all 1s, held while reset is high
  - core_start = 0, core_stop = 0
  - busy = 0, done = 0, found = 0
  - found_key = 0, found_core = 0, core_key_start = 0
- Partitioning:
  - PART = (KEY_MAX+1)/NUM_CORES
  - start_i = i*PART, end_i = start_i + PART - 1
  - Default values: PART = 0x100000, core 3 covers 0x300000..0x3FFFFF.
  - Computed as constants; no runtime division.
- State machine: IDLE -> RST -> LAUNCH -> RUN -> DONE.
- IDLE:
  - core_reset = 0.
  - On start=1, go to RST.
- RST (1 cycle):
  - core_reset = all 1s; core_key_start loaded with the partition start keys.
  - Clear finished[], found, found_key, found_core.
  - busy = 1.
- LAUNCH (1 cycle):
  - core_reset = 0; core_start = all 1s.
  - Next state is RUN.
- RUN: evaluated every cycle for each core i.
  - If core_done[i] & core_found[i]:
    - Capture found_key = core_key[i] and found_core = i.
    - The lowest index wins on simultaneous finds.
    - core_stop = all 1s; go to DONE with found=1.
  - Else if core_key[i] > end_i, or core_done[i] without found:
    - Set finished[i] and core_stop[i] = 1.
    - Overshoot of up to one key past end_i is tolerated.
  - When all finished[] are set, go to DONE with found=0.
  - If abort=1, core_stop = all 1s and go to DONE with found=0. A find in the same cycle as abort takes priority over the abort.
- DONE:
  - done = 1, busy = 0; core_stop stays at its last value; results held.
  - On start=1, go to RST (new search).
  - abort in DONE is ignored.
- core_key_start is constant from RST until the next RST.
- Reset during RUN stops the search immediately: cores are held in reset and no result is reported.
- Latency: start sampled at edge 0 -> core_start high in cycle 2 -> first found reported one cycle after core_done & core_found are seen.

Decomposition:
- Package key_search_pkg holds:
  - sched_state_t enum (IDLE, RST, LAUNCH, RUN, DONE)
  - KEY_WIDTH and KEY_MAX constants
  - a function for the partition start/end of core i
- Sub-module found_arbiter: a combinational lowest-index priority encoder that takes core_done & core_found and produces a valid bit and an index. It is instantiated once.

Test Plan:
- Single core found, NUM_CORES=4: start=1 with a behavioural core model where core 2 reaches key 0x200049 and raises done and found -> found=1, found_key=0x200049, found_core=2, core_stop=4'b1111, done=1 on the next cycle.
- Partition overrun: core 1 key advances to 0x200000 -> core_stop[1]=1 on the next cycle, the others stay 0. All cores overrun -> done=1, found=0.
- Simultaneous find: cores 3 and 1 raise done and found in the same cycle with keys 0x3000AA and 0x100011 -> found_core=1, found_key=0x100011.
- Launch sequence: start pulsed -> core_key_start = {0x300000, 0x200000, 0x100000, 0x000000}, core_reset=1111 for exactly one cycle, then core_start=1111 for exactly one cycle.
- Abort during RUN -> all core_stop high, done=1, found=0. Abort coinciding with a find on core 0 -> found=1, found_core=0.
- Reset asserted mid-RUN -> next cycle: busy=0, done=0, core_reset=1111, core_start=0. A fresh start after reset is released completes normally.
